// File: rtl/btn_toggle_debounce_pkg.sv
// Shared debounce definitions: FSM state encodings and default timing parameters.
package btn_toggle_debounce_pkg;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_CNT_W         = 8;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_e;

endpackage

// File: rtl/sync_ff_chain.sv
// Parameterised flop-chain synchroniser for one asynchronous input, synchronous clear.
// Latency STAGES cycles; no flow control.
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (clr) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/btn_toggle_debounce.sv
// Debounces a raw push-button into a level plus one-cycle press (T) and release (REL) pulses.
// Latency SYNC_STAGES+STABLE_CYCLES edges from a stable input change; no flow control.
module btn_toggle_debounce
  import btn_toggle_debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic CLK,
  input  logic CLR,
  input  logic BTN,
  output logic T,
  output logic REL,
  output logic LEVEL
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             t_q, t_d;
  logic             rel_q, rel_d;
  logic             level_q, level_d;

  sync_ff_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(CLK),
    .clr(CLR),
    .d  (BTN),
    .q  (s)
  );

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      t_q     <= 1'b0;
      rel_q   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      rel_q   <= rel_d;
      level_q <= level_d;
    end
  end

  // Any sample disagreeing with the candidate level aborts qualification.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = 1'b0;
    rel_d   = 1'b0;
    level_d = level_q;
    case (state_q)
      IDLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          level_d = 1'b1;
          t_d     = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          level_d = 1'b0;
          rel_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign T     = t_q;
  assign REL   = rel_q;
  assign LEVEL = level_q;

endmodule

// File: tb/tb_btn_toggle_debounce.sv
// Directed bench for btn_toggle_debounce with default parameters (press/release latency 6 edges).
module tb_btn_toggle_debounce;

  logic CLK;
  logic CLR;
  logic BTN;
  logic T;
  logic REL;
  logic LEVEL;

  int checks = 0;
  int errors = 0;

  btn_toggle_debounce dut (
    .CLK  (CLK),
    .CLR  (CLR),
    .BTN  (BTN),
    .T    (T),
    .REL  (REL),
    .LEVEL(LEVEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n edges, counting T and REL pulses and any cycle where both are high.
  task automatic run(input int n, output int tc, output int rc, output int both);
    tc = 0;
    rc = 0;
    both = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (T === 1'b1) tc++;
      if (REL === 1'b1) rc++;
      if (T === 1'b1 && REL === 1'b1) both++;
    end
  endtask

  initial begin
    int tc, rc, both;
    BTN = 1'b0;
    CLR = 1'b1;

    // Reset held for 2 cycles with the button already pressed.
    BTN = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_T", T, 1'b0);
      chk("rst_REL", REL, 1'b0);
      chk("rst_LEVEL", LEVEL, 1'b0);
    end
    CLR = 1'b0;
    run(5, tc, rc, both);
    chk_n("post_rst_early_T", tc, 0);
    chk("post_rst_level_e5", LEVEL, 1'b0);
    tick();
    chk("post_rst_T_e6", T, 1'b1);
    chk("post_rst_LEVEL_e6", LEVEL, 1'b1);
    tick();
    chk("post_rst_T_e7", T, 1'b0);

    // Release: REL on edge 6, T untouched.
    BTN = 1'b0;
    run(5, tc, rc, both);
    chk_n("rel_early_REL", rc, 0);
    chk("rel_level_e5", LEVEL, 1'b1);
    tick();
    chk("rel_REL_e6", REL, 1'b1);
    chk("rel_LEVEL_e6", LEVEL, 1'b0);
    chk("rel_T_e6", T, 1'b0);
    tick();
    chk("rel_REL_e7", REL, 1'b0);

    // Clean press held 20 cycles: single T at edge 6, no repeat.
    BTN = 1'b1;
    run(5, tc, rc, both);
    chk_n("press_early_T", tc, 0);
    tick();
    chk("press_T_e6", T, 1'b1);
    chk("press_LEVEL_e6", LEVEL, 1'b1);
    run(14, tc, rc, both);
    chk_n("press_held_T", tc, 0);
    chk("press_held_LEVEL", LEVEL, 1'b1);
    BTN = 1'b0;
    run(10, tc, rc, both);
    chk_n("press_release_REL", rc, 1);
    chk("press_release_LEVEL", LEVEL, 1'b0);

    // Glitch: 3 cycles high is one sample short of qualifying.
    BTN = 1'b1;
    tick();
    tick();
    tick();
    BTN = 1'b0;
    run(15, tc, rc, both);
    chk_n("glitch_T", tc, 0);
    chk("glitch_LEVEL", LEVEL, 1'b0);
    // Back in IDLE_LOW: a fresh press qualifies with full latency.
    BTN = 1'b1;
    run(5, tc, rc, both);
    chk_n("glitch_recover_early", tc, 0);
    tick();
    chk("glitch_recover_T_e6", T, 1'b1);
    BTN = 1'b0;
    run(10, tc, rc, both);
    chk_n("glitch_recover_REL", rc, 1);

    // Bounce 1,0,1,0,1 then hold: T on the 6th edge counting from the final rise.
    BTN = 1'b1; tick();
    BTN = 1'b0; tick();
    BTN = 1'b1; tick();
    BTN = 1'b0; tick();
    BTN = 1'b1; tick();
    chk("bounce_T_e5", T, 1'b0);
    run(4, tc, rc, both);
    chk_n("bounce_early_T", tc, 0);
    tick();
    chk("bounce_T_e10", T, 1'b1);
    run(10, tc, rc, both);
    chk_n("bounce_after_T", tc, 0);
    chk("bounce_LEVEL", LEVEL, 1'b1);
    BTN = 1'b0;
    run(10, tc, rc, both);
    chk_n("bounce_release_REL", rc, 1);
    chk_n("bounce_release_T", tc, 0);

    // Reset in WAIT_HIGH with cnt=2 (after edge 4), button kept high.
    BTN = 1'b1;
    run(4, tc, rc, both);
    CLR = 1'b1;
    tick();
    chk("midrst_T_a", T, 1'b0);
    chk("midrst_LEVEL_a", LEVEL, 1'b0);
    tick();
    chk("midrst_T_b", T, 1'b0);
    CLR = 1'b0;
    run(5, tc, rc, both);
    chk_n("midrst_early_T", tc, 0);
    chk("midrst_LEVEL_e5", LEVEL, 1'b0);
    tick();
    chk("midrst_T_e6", T, 1'b1);
    run(10, tc, rc, both);
    chk_n("midrst_after_T", tc, 0);
    chk_n("midrst_both", both, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
